// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Shared state, opcode and PC-select encodings for the PC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EXE  = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] PCSEL_PC4 = 3'b000;
  localparam logic [2:0] PCSEL_BR  = 3'b001;
  localparam logic [2:0] PCSEL_JMP = 3'b010;
  localparam logic [2:0] PCSEL_JR  = 3'b011;
  localparam logic [2:0] PCSEL_RST = 3'b100;

  // Exactly one field is set for any opcode/funct pair.
  typedef struct packed {
    logic jump;
    logic jal;
    logic jr;
    logic branch;
    logic alu;
    logic load;
    logic store;
    logic halt;
    logic illegal;
  } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_pc_ctrl_if
// Brief    : IR fields in, PC/IR/regfile/memory controls and status out.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_pc_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [2:0]  PCSel;
  logic        bne;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;
  logic [31:0] instret;

  // The sequencer is the master: it owns every control and status line.
  modport master (
    input  opcode, funct,
    output PCSel, bne, PCWrite, IRWrite, RegWrite, MemWrite,
    output state, halted, illegal, instret
  );

  modport slave (
    output opcode, funct,
    input  PCSel, bne, PCWrite, IRWrite, RegWrite, MemWrite,
    input  state, halted, illegal, instret
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_pc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_class_decode
// Brief    : Combinational opcode/funct to one-hot instruction class.
// Revision : 1.0 - initial release
// ============================================================================
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output instr_class_t o_class
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_RTYPE: begin
        if (i_funct == FUNCT_JR) o_class.jr  = 1'b1;
        else                     o_class.alu = 1'b1;
      end
      OP_J:           o_class.jump    = 1'b1;
      OP_JAL:         o_class.jal     = 1'b1;
      OP_BEQ, OP_BNE: o_class.branch  = 1'b1;
      OP_ADDI:        o_class.alu     = 1'b1;
      OP_LW:          o_class.load    = 1'b1;
      OP_SW:          o_class.store   = 1'b1;
      OP_HALT:        o_class.halt    = 1'b1;
      default:        o_class.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_pc_ctrl
// Brief    : Multi-cycle IF/ID/EXE/MEM/WB sequencer driving the PC unit selects
//            and datapath write enables, with a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_pc_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  multicycle_pc_ctrl_if.master bus
);

  state_t       r_state;
  state_t       w_next;
  logic         r_illegal;
  logic [31:0]  r_instret;
  instr_class_t w_cls;

  logic [2:0]   w_pcsel;
  logic         w_bne;
  logic         w_pcwrite;
  logic         w_irwrite;
  logic         w_regwrite;
  logic         w_memwrite;
  logic         w_retire;
  logic         w_set_illegal;

  instr_class_decode u_decode (
    .i_opcode (bus.opcode),
    .i_funct  (bus.funct),
    .o_class  (w_cls)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_INIT;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | w_set_illegal;
      // Unconditional add keeps the counter free-running with natural wrap.
      r_instret <= r_instret + {31'd0, w_retire};
    end
  end

  always_comb begin
    w_next        = r_state;
    w_pcsel       = PCSEL_PC4;
    w_bne         = 1'b0;
    w_pcwrite     = 1'b0;
    w_irwrite     = 1'b0;
    w_regwrite    = 1'b0;
    w_memwrite    = 1'b0;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_pcsel   = PCSEL_RST;
        w_pcwrite = 1'b1;
        w_next    = ST_IF;
      end
      ST_IF: begin
        w_irwrite = 1'b1;
        w_next    = ST_ID;
      end
      ST_ID: begin
        if (w_cls.jump || w_cls.jal) begin
          w_pcsel    = PCSEL_JMP;
          w_pcwrite  = 1'b1;
          w_regwrite = w_cls.jal;
          w_retire   = 1'b1;
          w_next     = ST_IF;
        end else if (w_cls.jr) begin
          w_pcsel   = PCSEL_JR;
          w_pcwrite = 1'b1;
          w_retire  = 1'b1;
          w_next    = ST_IF;
        end else if (w_cls.halt) begin
          w_retire = 1'b1;
          w_next   = ST_HALT;
        end else if (w_cls.illegal) begin
          w_set_illegal = 1'b1;
          w_next        = ST_HALT;
        end else begin
          w_next = ST_EXE;
        end
      end
      ST_EXE: begin
        if (w_cls.branch) begin
          // The PC unit resolves taken/not-taken from zero; we only pass the sense.
          w_pcsel   = PCSEL_BR;
          w_bne     = bus.opcode[0];
          w_pcwrite = 1'b1;
          w_retire  = 1'b1;
          w_next    = ST_IF;
        end else if (w_cls.load || w_cls.store) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        if (w_cls.store) begin
          w_memwrite = 1'b1;
          w_pcwrite  = 1'b1;
          w_retire   = 1'b1;
          w_next     = ST_IF;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_WB: begin
        w_regwrite = 1'b1;
        w_pcwrite  = 1'b1;
        w_retire   = 1'b1;
        w_next     = ST_IF;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_INIT;
    endcase
  end

  assign bus.PCSel    = w_pcsel;
  assign bus.bne      = w_bne;
  assign bus.PCWrite  = w_pcwrite;
  assign bus.IRWrite  = w_irwrite;
  assign bus.RegWrite = w_regwrite;
  assign bus.MemWrite = w_memwrite;
  assign bus.state    = r_state;
  assign bus.halted   = (r_state == ST_HALT);
  assign bus.illegal  = r_illegal;
  assign bus.instret  = r_instret;

endmodule
`default_nettype wire
